// File: rtl/chassis_speed_pi.sv
// chassis_speed_pi: quadrature-encoder wheel speed measurement plus a PI speed
// loop. One PI evaluation per sample window drives a saturated, sign-extended
// duty word to the downstream PWM/H-bridge stage.
module chassis_speed_pi #(
  parameter int SAMPLE_CYCLES = 50000,
  parameter int KP            = 16,
  parameter int KI            = 2,
  parameter int SHIFT         = 4,
  parameter int INT_MAX       = 1048576,
  parameter int DUTY_MAX      = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic signed [15:0] setpoint,
  output logic signed [15:0] speed,
  output logic signed [39:0] duty,
  output logic               duty_valid,
  output logic               enc_err
);

  localparam int                     WIN_W      = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [WIN_W-1:0]       WIN_LAST   = WIN_W'(SAMPLE_CYCLES - 1);
  localparam logic signed [47:0]     KP_S       = 48'(KP);
  localparam logic signed [47:0]     KI_S       = 48'(KI);
  localparam logic signed [31:0]     INT_MAX_S  = 32'(INT_MAX);
  localparam logic signed [47:0]     DUTY_MAX_S = 48'(DUTY_MAX);
  localparam logic signed [23:0]     DUTY_MAX_24 = 24'(DUTY_MAX);

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_MUL, S_SUM, S_SAT} state_t;

  // Position of an {A,B} pair along the forward Gray sequence 00,01,11,10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_pos = 2'd0;
      2'b01:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  function automatic logic signed [15:0] sat_edge(input logic signed [16:0] v);
    if (v > 17'sd32767)       sat_edge = 16'sh7FFF;
    else if (v < -17'sd32768) sat_edge = 16'sh8000;
    else                      sat_edge = v[15:0];
  endfunction

  function automatic logic signed [31:0] sat_integ(input logic signed [31:0] v);
    if (v > INT_MAX_S)       sat_integ = INT_MAX_S;
    else if (v < -INT_MAX_S) sat_integ = -INT_MAX_S;
    else                     sat_integ = v;
  endfunction

  function automatic logic signed [23:0] sat_duty(input logic signed [47:0] v);
    if (v > DUTY_MAX_S)       sat_duty = DUTY_MAX_24;
    else if (v < -DUTY_MAX_S) sat_duty = -DUTY_MAX_24;
    else                      sat_duty = v[23:0];
  endfunction

  logic                     r_a_s1, r_a_s2, r_b_s1, r_b_s2;
  logic [1:0]               r_ab_prev;
  logic [WIN_W-1:0]         r_win;
  logic signed [15:0]       r_edge_cnt;
  logic signed [15:0]       r_speed;
  logic                     r_enc_err;
  state_t                   r_state, w_state_nxt;
  logic signed [31:0]       r_integ;
  logic signed [39:0]       r_duty;
  logic                     r_duty_valid;
  logic signed [16:0]       r_err_p0;
  logic signed [31:0]       r_integ_n_p0;
  logic signed [47:0]       r_p_p1, r_i_p1;

  logic [1:0]               w_ab_cur, w_step;
  logic signed [1:0]        w_delta;
  logic                     w_illegal, w_tick;
  logic signed [16:0]       w_edge_sum;
  logic signed [15:0]       w_edge_nxt;
  logic signed [16:0]       w_err;
  logic signed [31:0]       w_integ_sum, w_integ_n;
  logic signed [47:0]       w_s;
  logic signed [23:0]       w_duty24;
  logic                     w_clamped, w_same_sign;

  assign w_ab_cur   = {r_a_s2, r_b_s2};
  assign w_step     = gray_pos(w_ab_cur) - gray_pos(r_ab_prev);
  assign w_delta    = (w_step == 2'd1) ? 2'sb01 : (w_step == 2'd3) ? 2'sb11 : 2'sb00;
  assign w_illegal  = (w_step == 2'd2);
  assign w_tick     = (r_win == WIN_LAST);
  assign w_edge_sum = $signed({r_edge_cnt[15], r_edge_cnt}) + $signed({{15{w_delta[1]}}, w_delta});
  assign w_edge_nxt = sat_edge(w_edge_sum);

  assign w_err       = $signed({setpoint[15], setpoint}) - $signed({r_speed[15], r_speed});
  assign w_integ_sum = r_integ + $signed({{15{w_err[16]}}, w_err});
  assign w_integ_n   = sat_integ(w_integ_sum);

  assign w_s         = (r_p_p1 + r_i_p1) >>> SHIFT;
  assign w_duty24    = sat_duty(w_s);
  assign w_clamped   = (w_s > DUTY_MAX_S) || (w_s < -DUTY_MAX_S);
  assign w_same_sign = ((!r_err_p0[16] && (|r_err_p0)) && (!w_s[47] && (|w_s))) ||
                       (r_err_p0[16] && w_s[47]);

  assign speed      = r_speed;
  assign duty       = r_duty;
  assign duty_valid = r_duty_valid;
  assign enc_err    = r_enc_err;

  // Two-flop synchronisers on A/B plus the previous-sample history register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_s1    <= 1'b0;
      r_a_s2    <= 1'b0;
      r_b_s1    <= 1'b0;
      r_b_s2    <= 1'b0;
      r_ab_prev <= 2'b00;
    end else begin
      r_a_s1    <= enc_a;
      r_a_s2    <= r_a_s1;
      r_b_s1    <= enc_b;
      r_b_s2    <= r_b_s1;
      r_ab_prev <= w_ab_cur;
    end
  end

  // Window timing, saturating edge accumulation, speed capture and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win      <= '0;
      r_edge_cnt <= '0;
      r_speed    <= '0;
      r_enc_err  <= 1'b0;
    end else begin
      r_enc_err <= r_enc_err | w_illegal;
      if (w_tick) begin
        r_win      <= '0;
        r_speed    <= w_edge_nxt;
        r_edge_cnt <= '0;
      end else begin
        r_win      <= r_win + 1'b1;
        r_edge_cnt <= w_edge_nxt;
      end
    end
  end

  // PI sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // PI sequencer next state: one cycle per step, parked in IDLE while disabled.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_tick) w_state_nxt = S_ERR;
        S_ERR:   w_state_nxt = S_MUL;
        S_MUL:   w_state_nxt = S_SUM;
        S_SUM:   w_state_nxt = S_SAT;
        S_SAT:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath stages: p0 holds error and candidate integrator, p1 the products.
  always_ff @(posedge clk) begin
    if (r_state == S_ERR) begin
      r_err_p0     <= w_err;
      r_integ_n_p0 <= w_integ_n;
    end
    if (r_state == S_MUL) begin
      r_p_p1 <= KP_S * $signed({{31{r_err_p0[16]}}, r_err_p0});
      r_i_p1 <= KI_S * $signed({{16{r_integ_n_p0[31]}}, r_integ_n_p0});
    end
  end

  // Duty/integrator commit: duty lands with valid in the SAT cycle; the
  // integrator freezes when the output is pinned and the error pushes further.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_duty       <= '0;
      r_duty_valid <= 1'b0;
      r_integ      <= '0;
    end else if (!enable) begin
      r_duty       <= '0;
      r_duty_valid <= 1'b0;
      r_integ      <= '0;
    end else begin
      r_duty_valid <= (r_state == S_SUM);
      if (r_state == S_SUM) begin
        r_duty <= {{16{w_duty24[23]}}, w_duty24};
        if (!(w_clamped && w_same_sign)) r_integ <= r_integ_n_p0;
      end
    end
  end

endmodule

// File: tb/tb_chassis_speed_pi.sv
// Bench for chassis_speed_pi: window-by-window stimulus with a behavioural
// model of edge counting and the PI law.
module tb_chassis_speed_pi;
  localparam int  SC   = 100;
  localparam longint KP   = 16;
  localparam longint KI   = 2;
  localparam longint IMAX = 1048576;
  localparam longint DMAX = 50000;

  logic               clk = 1'b0;
  logic               reset, enable, enc_a, enc_b;
  logic signed [15:0] setpoint;
  logic signed [15:0] speed;
  logic signed [39:0] duty;
  logic               duty_valid, enc_err;

  chassis_speed_pi #(.SAMPLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .enc_a(enc_a), .enc_b(enc_b),
    .setpoint(setpoint), .speed(speed), .duty(duty), .duty_valid(duty_valid),
    .enc_err(enc_err)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  longint     m_speed, m_integ, m_duty;
  bit         m_pend, m_err;
  int         enc_idx;
  logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic drive_enc();
    {enc_a, enc_b} = gray_tab[enc_idx];
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    enc_idx = 0;
    drive_enc();
    #1;
    chk("rst_speed", longint'(speed), 0);
    chk("rst_duty", longint'(duty), 0);
    chk("rst_valid", longint'(duty_valid), 0);
    chk("rst_enc_err", longint'(enc_err), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_speed = 0; m_integ = 0; m_duty = 0; m_pend = 0; m_err = 0;
  endtask

  // One sample window, entered on the negedge where the window counter is 0.
  // dir: +1/-1 all forward/reverse, 0 random. drop_w/rst_w: window phase at
  // which enable drops / reset asserts (-1 for none).
  task automatic window(input int moves, input int dir, input bit ill, input bit edge97,
                        input int drop_w, input int rst_w);
    int     plan [100];
    int     net;
    longint e, in_n, s, d, new_duty, exp_duty;
    bit     gen, dropped;
    for (int i = 0; i < 100; i++) plan[i] = 0;
    net = 0;
    for (int k = 0; k < moves; k++)
      plan[10 + 2*k] = (dir != 0) ? dir : (($urandom_range(0, 1) == 1) ? 1 : -1);
    if (ill) plan[92] = 2;
    if (edge97) plan[97] = 1;
    dropped = (drop_w >= 0);
    gen = m_pend && !(drop_w >= 0 && drop_w <= 2);
    new_duty = m_duty;
    if (gen) begin
      e = longint'(setpoint) - m_speed;
      in_n = m_integ + e;
      if (in_n > IMAX) in_n = IMAX;
      if (in_n < -IMAX) in_n = -IMAX;
      s = (KP*e + KI*in_n) >>> 4;
      d = (s > DMAX) ? DMAX : (s < -DMAX) ? -DMAX : s;
      if (!((d != s) && ((e > 0 && s > 0) || (e < 0 && s < 0)))) m_integ = in_n;
      new_duty = d;
    end
    for (int w = 0; w < 100; w++) begin
      if (w == rst_w) begin
        apply_reset();
        return;
      end
      if (gen && w >= 3)             exp_duty = new_duty;
      else if (dropped && w > drop_w) exp_duty = 0;
      else                            exp_duty = m_duty;
      chk($sformatf("valid@w%0d", w), longint'(duty_valid), (gen && w == 3) ? 1 : 0);
      chk($sformatf("duty@w%0d", w), longint'(duty), exp_duty);
      if (gen && w == 3)
        chk("duty_hi", longint'(duty[39:23]), (new_duty < 0) ? 'h1FFFF : 0);
      if (w == 0) chk("speed", longint'(speed), m_speed);
      if (w == drop_w) enable = 1'b0;
      if (plan[w] != 0) begin
        enc_idx = (enc_idx + ((plan[w] == -1) ? 3 : plan[w])) % 4;
        drive_enc();
        if (plan[w] == 2) m_err = 1;
        else net += plan[w];
      end
      @(negedge clk);
    end
    if (!enable) begin
      m_integ = 0;
      m_duty = 0;
    end else begin
      m_duty = new_duty;
    end
    m_speed = (net > 32767) ? 32767 : (net < -32768) ? -32768 : net;
    m_pend = enable;
    chk("enc_err", longint'(enc_err), longint'(m_err));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; enc_a = 1'b0; enc_b = 1'b0; setpoint = '0; enc_idx = 0;
    #2;
    apply_reset();
    enable = 1'b1;
    setpoint = 16'sd100;
    // Open loop: 112, 125, 137 in windows 2..4
    repeat (4) window(0, 0, 0, 0, -1, -1);
    // Decode: forward, reverse, edge on the tick cycle, illegal transition
    window(40, 1, 0, 0, -1, -1);
    window(40, -1, 0, 0, -1, -1);
    window(0, 0, 0, 1, -1, -1);
    window(0, 0, 1, 0, -1, -1);
    repeat (3) window(0, 0, 0, 0, -1, -1);
    // Saturation and anti-windup in both directions
    setpoint = 16'sd32767;
    repeat (7) window(0, 0, 0, 0, -1, -1);
    setpoint = 16'sd0;
    window(0, 0, 0, 0, -1, -1);
    setpoint = -16'sd32768;
    repeat (12) window(0, 0, 0, 0, -1, -1);
    // Enable drop during MUL, then re-enable
    setpoint = 16'sd100;
    window(0, 0, 0, 0, 1, -1);
    window(0, 0, 0, 0, -1, -1);
    enable = 1'b1;
    repeat (2) window(0, 0, 0, 0, -1, -1);
    // Random setpoints and encoder motion
    repeat (8) begin
      setpoint = 16'(int'($urandom_range(0, 600)) - 300);
      window(int'($urandom_range(0, 40)), 0, 0, 0, -1, -1);
    end
    // Reset during SUM, then recovery
    window(5, 1, 0, 0, -1, 2);
    setpoint = 16'sd100;
    repeat (3) window(0, 0, 0, 0, -1, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
